// File: rtl/arb_req_pkg.sv
// Shared types and sizing helpers for the arbiter request controller.
// Pure declarations: no logic, no latency, no flow control.
package arb_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam int DEF_DEPTH       = 4;
  localparam int DEF_BURST_LEN   = 4;
  localparam int DEF_TIMEOUT_CYC = 16;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int burst_w(input int len);
    return $clog2(len + 1);
  endfunction

  function automatic int wait_w(input int cyc);
    return $clog2(cyc + 1);
  endfunction

  localparam int BURST_W = burst_w(DEF_BURST_LEN);
  localparam int WAIT_W  = wait_w(DEF_TIMEOUT_CYC);

endpackage

// File: rtl/arb_req_ctrl_if.sv
// Job/arbiter-facing bundle of the request controller; slave = controller side.
// Signals only: timing and backpressure are defined by the controller.
interface arb_req_ctrl_if #(
  parameter int N_CLI = 2,
  parameter int DEPTH = 4
);
  localparam int CW = arb_req_pkg::cnt_w(DEPTH);

  logic [N_CLI-1:0]    job_valid;
  logic [N_CLI-1:0]    job_ready;
  logic [N_CLI-1:0]    grant;
  logic [N_CLI-1:0]    request;
  logic [N_CLI-1:0]    busy;
  logic [N_CLI-1:0]    done;
  logic [N_CLI*CW-1:0] pend_cnt;
  logic [N_CLI-1:0]    timeout_err;
  logic                err_clr;

  modport slave (
    input  job_valid, grant, err_clr,
    output job_ready, request, busy, done, pend_cnt, timeout_err
  );

  modport master (
    output job_valid, grant, err_clr,
    input  job_ready, request, busy, done, pend_cnt, timeout_err
  );
endinterface

// File: rtl/arb_req_client.sv
// One client: pending-job counter plus IDLE/REQ/XFER request FSM; job to request = 2 edges.
// job_ready drops at DEPTH pending; ARB_REQ_TIMEOUT_EN adds the REQ wait timeout.
module arb_req_client
  import arb_req_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_job_valid,
  input  logic                    i_grant,
  input  logic                    i_err_clr,
  output logic                    o_job_ready,
  output logic                    o_request,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_timeout_err,
  output logic [cnt_w(DEPTH)-1:0] o_pend
);
  localparam int CW = cnt_w(DEPTH);
  localparam int BW = burst_w(BURST_LEN);
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_pend;
  logic [BW-1:0] r_burst;
  logic          r_done;
  logic          w_ready;
  logic          w_take;
  logic          w_grant_hit;
  logic          w_burst_end;
  logic          w_wait_exp;

  assign w_ready = (r_pend < DEPTH_C);
  assign w_take  = i_job_valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_hit = 1'b0;
    w_burst_end = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pend != '0) w_state_nxt = REQ;
      end
      REQ: begin
        if (i_grant) begin
          w_state_nxt = XFER;
          w_grant_hit = 1'b1;
        end else if (w_wait_exp) begin
          w_state_nxt = IDLE;
        end
      end
      XFER: begin
        // a lost grant aborts the burst; the job stays pending for a full retry
        if (!i_grant) begin
          w_state_nxt = REQ;
        end else if (r_burst == '0) begin
          w_state_nxt = IDLE;
          w_burst_end = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_request   = (r_state != IDLE);
    o_busy      = (r_state == XFER);
    o_done      = r_done;
    o_pend      = r_pend;
    o_job_ready = w_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_burst <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_burst_end;
      if (w_take && !w_burst_end)      r_pend <= r_pend + CW'(1);
      else if (!w_take && w_burst_end) r_pend <= r_pend - CW'(1);
      if (w_grant_hit)
        r_burst <= BURST_LAST;
      else if ((r_state == XFER) && i_grant && (r_burst != '0))
        r_burst <= r_burst - BW'(1);
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WW = wait_w(TIMEOUT_CYC);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYC - 1);

  logic [WW-1:0] r_wait;
  logic          r_err;

  assign w_wait_exp    = (r_state == REQ) && !i_grant && (r_wait == WAIT_LAST);
  assign o_timeout_err = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      if ((r_state != REQ) || i_grant || w_wait_exp) r_wait <= '0;
      else                                           r_wait <= r_wait + WW'(1);
      // clear wins over a same-cycle timeout
      r_err <= i_err_clr ? 1'b0 : (r_err | w_wait_exp);
    end
  end
`else
  logic w_unused;

  assign w_wait_exp    = 1'b0;
  assign o_timeout_err = 1'b0;
  assign w_unused      = i_err_clr ^ (TIMEOUT_CYC == 0);
`endif

endmodule

// File: rtl/arb_req_ctrl.sv
// Request controller for an N_CLI-client arbiter; packs per-client lanes onto the bus.
// Latency and backpressure are per client (see arb_req_client); ARB_REQ_TIMEOUT_EN selects timeout.
module arb_req_ctrl
  import arb_req_pkg::*;
#(
  parameter int N_CLI       = 2,
  parameter int DEPTH       = 4,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input logic           clk,
  input logic           rst_n,
  arb_req_ctrl_if.slave bus
);
  localparam int CW = cnt_w(DEPTH);

  for (genvar g = 0; g < N_CLI; g++) begin : g_cli
    arb_req_client #(
      .DEPTH       (DEPTH),
      .BURST_LEN   (BURST_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_client (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_job_valid   (bus.job_valid[g]),
      .i_grant       (bus.grant[g]),
      .i_err_clr     (bus.err_clr),
      .o_job_ready   (bus.job_ready[g]),
      .o_request     (bus.request[g]),
      .o_busy        (bus.busy[g]),
      .o_done        (bus.done[g]),
      .o_timeout_err (bus.timeout_err[g]),
      .o_pend        (bus.pend_cnt[g*CW +: CW])
    );
  end

endmodule

// File: tb/tb_arb_req_ctrl.sv
// Bench for arb_req_ctrl: directed vector table, timeout/reset sequences, random run vs model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_arb_req_ctrl;
  localparam int DEPTH       = 4;
  localparam int BURST_LEN   = 4;
  localparam int TIMEOUT_CYC = 16;
`ifdef ARB_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [15:0] RST_EXP = {2'b00, 2'b00, 2'b00, 2'b11, 6'd0, 2'b00};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  arb_req_ctrl_if #(.N_CLI(2), .DEPTH(DEPTH)) bus ();

  arb_req_ctrl #(
    .N_CLI(2), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       rst;
    logic [1:0] jv, g, req, busy, done, rdy;
    logic [2:0] p0, p1;
  } vec_t;

  vec_t tbl[$];

  // behavioural model state
  int m_pend[2], m_left[2], m_wait[2];
  bit m_req[2], m_busy[2], m_done[2], m_err[2];

  function automatic void add(input int rst, jv, g, req, busy, done, rdy, p0, p1);
    vec_t v;
    v.rst = 1'(rst); v.jv = 2'(jv); v.g = 2'(g); v.req = 2'(req); v.busy = 2'(busy);
    v.done = 2'(done); v.rdy = 2'(rdy); v.p0 = 3'(p0); v.p1 = 3'(p1);
    tbl.push_back(v);
  endfunction

  function automatic logic [15:0] outs();
    return {bus.request, bus.busy, bus.done, bus.job_ready, bus.pend_cnt, bus.timeout_err};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (req,busy,done,rdy,p1,p0,err)", name, act, exp);
    end
  endtask

  task automatic apply(input logic [1:0] jv, input logic [1:0] g, input logic clr);
    bus.job_valid = jv;
    bus.grant     = g;
    bus.err_clr   = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_left[i] = 0; m_wait[i] = 0;
      m_req[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_err[i] = 0;
    end
  endtask

  task automatic do_reset();
    bus.job_valid = '0; bus.grant = '0; bus.err_clr = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("reset", outs(), RST_EXP);
  endtask

  // one clock of the client rules: jobs queue, a request waits for grant, a burst serves BURST_LEN cycles
  task automatic model_step(input logic [1:0] jv, input logic [1:0] g, input logic clr);
    bit take, fin, to;
    for (int i = 0; i < 2; i++) begin
      take = jv[i] && (m_pend[i] < DEPTH);
      fin = 0; to = 0;
      if (!m_req[i]) begin
        if (m_pend[i] > 0) begin m_req[i] = 1; m_wait[i] = 0; end
      end else if (!m_busy[i]) begin
        if (g[i]) begin
          m_busy[i] = 1; m_left[i] = BURST_LEN; m_wait[i] = 0;
        end else begin
          m_wait[i]++;
          if (TO_EN && m_wait[i] >= TIMEOUT_CYC) begin m_req[i] = 0; to = 1; end
        end
      end else if (!g[i]) begin
        m_busy[i] = 0; m_wait[i] = 0;
      end else begin
        m_left[i]--;
        if (m_left[i] == 0) begin fin = 1; m_busy[i] = 0; m_req[i] = 0; end
      end
      m_done[i] = fin;
      m_pend[i] = m_pend[i] + int'(take) - int'(fin);
      m_err[i]  = clr ? 1'b0 : (m_err[i] | to);
    end
  endtask

  function automatic logic [15:0] model_outs();
    logic [1:0] r, b, d, y, e;
    for (int i = 0; i < 2; i++) begin
      r[i] = m_req[i]; b[i] = m_busy[i]; d[i] = m_done[i];
      y[i] = (m_pend[i] < DEPTH); e[i] = m_err[i];
    end
    return {r, b, d, y, 3'(m_pend[1]), 3'(m_pend[0]), e};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0] jv, g;
    logic       clr;
    logic [15:0] exp_v;
    int pg;

    bus.job_valid = '0; bus.grant = '0; bus.err_clr = 1'b0;

    // single job, grant follows request one cycle late; grant in IDLE ignored
    add(1, 1, 0, 0, 0, 0, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0, 3, 1, 0);
    add(0, 0, 0, 1, 0, 0, 3, 1, 0);
    for (int k = 0; k < 4; k++) add(0, 0, 1, 1, 1, 0, 3, 1, 0);
    add(0, 0, 1, 0, 0, 1, 3, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0, 0);
    // saturation on client 1, then job and done on the same edge
    add(1, 2, 0, 0, 0, 0, 3, 0, 1);
    add(0, 2, 0, 2, 0, 0, 3, 0, 2);
    add(0, 2, 0, 2, 0, 0, 3, 0, 3);
    for (int k = 0; k < 3; k++) add(0, 2, 0, 2, 0, 0, 1, 0, 4);
    for (int k = 0; k < 4; k++) add(0, 0, 2, 2, 2, 0, 1, 0, 4);
    add(0, 0, 2, 0, 0, 2, 3, 0, 3);
    add(0, 0, 0, 2, 0, 0, 3, 0, 3);
    for (int k = 0; k < 4; k++) add(0, 0, 2, 2, 2, 0, 3, 0, 3);
    add(0, 2, 2, 0, 0, 2, 3, 0, 3);
    add(0, 0, 0, 2, 0, 0, 3, 0, 3);
    // grant lost on the second burst cycle, then a full burst
    add(1, 2, 0, 0, 0, 0, 3, 0, 1);
    add(0, 0, 0, 2, 0, 0, 3, 0, 1);
    add(0, 0, 2, 2, 2, 0, 3, 0, 1);
    add(0, 0, 2, 2, 2, 0, 3, 0, 1);
    add(0, 0, 0, 2, 0, 0, 3, 0, 1);
    add(0, 0, 0, 2, 0, 0, 3, 0, 1);
    for (int k = 0; k < 4; k++) add(0, 0, 2, 2, 2, 0, 3, 0, 1);
    add(0, 0, 2, 0, 0, 2, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0, 0);
    // both clients pending, grants alternate
    add(1, 3, 0, 0, 0, 0, 3, 1, 1);
    add(0, 0, 0, 3, 0, 0, 3, 1, 1);
    for (int k = 0; k < 4; k++) add(0, 0, 1, 3, 1, 0, 3, 1, 1);
    add(0, 0, 1, 2, 0, 1, 3, 0, 1);
    for (int k = 0; k < 4; k++) add(0, 0, 2, 2, 2, 0, 3, 0, 1);
    add(0, 0, 2, 0, 0, 2, 3, 0, 0);
    add(0, 0, 0, 0, 0, 0, 3, 0, 0);

    @(negedge clk);
    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      apply(tbl[k].jv, tbl[k].g, 1'b0);
      exp_v = {tbl[k].req, tbl[k].busy, tbl[k].done, tbl[k].rdy, tbl[k].p1, tbl[k].p0, 2'b00};
      check($sformatf("vec%0d", k), outs(), exp_v);
    end

    // waiting without grant: timeout behaviour (or indefinite wait when not built)
    do_reset();
    apply(2'b01, 2'b00, 1'b0);
    for (int t = 1; t <= 36; t++) begin
      clr = (t == 20 || t == 34);
      apply(2'b00, 2'b00, clr);
      if (TO_EN)
        exp_v = {13'd0, !(t == 17 || t == 34), (t >= 17 && t < 20), 1'b1};
      else
        exp_v = {13'd0, 1'b1, 1'b0, 1'b1};
      check($sformatf("wait_t%0d", t), {13'd0, bus.request[0], bus.timeout_err[0], bus.pend_cnt[0]}, exp_v);
    end

    // reset asserted mid-burst
    do_reset();
    apply(2'b01, 2'b00, 1'b0);
    apply(2'b00, 2'b00, 1'b0);
    apply(2'b00, 2'b01, 1'b0);
    apply(2'b00, 2'b01, 1'b0);
    check("midburst_busy", {14'd0, bus.busy}, 16'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), RST_EXP);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      apply(2'b00, 2'b01, 1'b0);
      check($sformatf("post_rst%0d", k), {12'd0, bus.request, bus.done}, 16'd0);
    end

    // randomized run against the model
    do_reset();
    pg = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) pg = (((c / 250) % 3) == 0) ? 1 : ((((c / 250) % 3) == 1) ? 4 : 8);
      for (int i = 0; i < 2; i++) begin
        jv[i] = ($urandom_range(0, 99) < 35);
        if (m_busy[i])     g[i] = ($urandom_range(0, 9) != 0);
        else if (m_req[i]) g[i] = ($urandom_range(0, 9) < pg);
        else               g[i] = ($urandom_range(0, 19) == 0);
      end
      clr = ($urandom_range(0, 49) == 0);
      apply(jv, g, clr);
      model_step(jv, g, clr);
      check($sformatf("rand%0d", c), outs(), model_outs());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
